// File: rtl/mem_display_driver.sv
// Four-digit hex display driver for the dual-port memory test block.
// Snapshots one read port per scan and multiplexes it onto the segments.
module mem_display_driver #(
  parameter int REFRESH_DIV = 50000,
  parameter int DWELL_SCANS = 250
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] ReadDataA,
  input  logic [15:0] ReadDataB,
  input  logic [1:0]  selMode,
  output logic [3:0]  anDisplay,
  output logic [7:0]  outDisplay
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int SW = (DWELL_SCANS > 1) ? $clog2(DWELL_SCANS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(DWELL_SCANS - 1);

  localparam logic [1:0] MODE_AUTO = 2'b00;
  localparam logic [1:0] MODE_A    = 2'b01;
  localparam logic [1:0] MODE_B    = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [SW-1:0] scans;
  logic          portB;
  logic [15:0]   snap;

  logic          tick;
  logic          wrap;
  logic          scanStart;
  logic [3:0]    nibble;
  logic [6:0]    hexSeg;

  assign tick      = (cnt == CNT_LAST);
  assign wrap      = tick && (idx == 2'd3);
  assign scanStart = (idx == 2'd0) && (cnt == '0);

  // Digit-period prescaler and digit index.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (tick) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Port selection, updated only at the end of a full scan.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scans <= '0;
      portB <= 1'b0;
    end else if (wrap) begin
      unique case (selMode)
        MODE_AUTO: begin
          if (scans == SCAN_LAST) begin
            scans <= '0;
            portB <= ~portB;
          end else begin
            scans <= scans + SW'(1);
          end
        end
        MODE_A: begin
          scans <= '0;
          portB <= 1'b0;
        end
        MODE_B: begin
          scans <= '0;
          portB <= 1'b1;
        end
        MODE_HOLD: begin
          scans <= scans;
          portB <= portB;
        end
      endcase
    end
  end

  // One coherent capture per scan so a changing word never tears.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      snap <= 16'h0000;
    end else if (scanStart && (selMode != MODE_HOLD)) begin
      snap <= portB ? ReadDataB : ReadDataA;
    end
  end

  // Hex-to-segment decode of the current digit's nibble.
  always_comb begin
    nibble = snap[{idx, 2'b00} +: 4];
    hexSeg = 7'h7F;
    unique case (nibble)
      4'h0: hexSeg = 7'h40;
      4'h1: hexSeg = 7'h79;
      4'h2: hexSeg = 7'h24;
      4'h3: hexSeg = 7'h30;
      4'h4: hexSeg = 7'h19;
      4'h5: hexSeg = 7'h12;
      4'h6: hexSeg = 7'h02;
      4'h7: hexSeg = 7'h78;
      4'h8: hexSeg = 7'h00;
      4'h9: hexSeg = 7'h10;
      4'hA: hexSeg = 7'h08;
      4'hB: hexSeg = 7'h03;
      4'hC: hexSeg = 7'h46;
      4'hD: hexSeg = 7'h21;
      4'hE: hexSeg = 7'h06;
      4'hF: hexSeg = 7'h0E;
    endcase
  end

  // Registered pin drive; first cycle of each digit is blanked.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      anDisplay  <= 4'b1111;
      outDisplay <= 8'hFF;
    end else if (cnt == '0) begin
      anDisplay  <= 4'b1111;
      outDisplay <= 8'hFF;
    end else begin
      anDisplay  <= ~(4'b0001 << idx);
      outDisplay <= {~((idx == 2'd0) && portB), hexSeg};
    end
  end

endmodule

// File: tb/tb_mem_display_driver.sv
// Directed bench for mem_display_driver.
// Small prescaler and dwell so every mode transition is reached quickly.
module tb_mem_display_driver;

  logic        clock;
  logic        reset;
  logic [15:0] ReadDataA;
  logic [15:0] ReadDataB;
  logic [1:0]  selMode;
  logic [3:0]  anDisplay;
  logic [7:0]  outDisplay;

  int errors = 0;
  int checks = 0;

  localparam logic [7:0] HEX [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  mem_display_driver #(
    .REFRESH_DIV(4),
    .DWELL_SCANS(2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .ReadDataA  (ReadDataA),
    .ReadDataB  (ReadDataB),
    .selMode    (selMode),
    .anDisplay  (anDisplay),
    .outDisplay (outDisplay)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [3:0] ea,
                     input logic [7:0] es);
    checks++;
    assert (anDisplay === ea) else begin
      errors++;
      $error("FAIL %s an: got %b want %b", tag, anDisplay, ea);
    end
    checks++;
    assert (outDisplay === es) else begin
      errors++;
      $error("FAIL %s seg: got %h want %h", tag, outDisplay, es);
    end
  endtask

  // Checks scan positions a..b (k = 4*idx + cnt of the pre-edge state).
  task automatic part(input string tag, input logic [15:0] word,
                      input logic dp, input int a, input int b);
    logic [3:0] ea;
    logic [7:0] es;
    logic [3:0] nib;
    int d;
    for (int k = a; k <= b; k++) begin
      @(negedge clock);
      d = k / 4;
      if ((k % 4) == 0) begin
        ea = 4'hF;
        es = 8'hFF;
      end else begin
        ea = 4'hF;
        ea[d] = 1'b0;
        nib = word[d*4 +: 4];
        es = HEX[nib];
        if (d == 0 && dp) es[7] = 1'b0;
      end
      chk($sformatf("%s k=%0d", tag, k), ea, es);
    end
  endtask

  task automatic scan(input string tag, input logic [15:0] word,
                      input logic dp);
    part(tag, word, dp, 0, 15);
  endtask

  initial begin
    reset     = 1'b0;
    ReadDataA = 16'h1234;
    ReadDataB = 16'hABCD;
    selMode   = 2'b00;
    repeat (3) @(negedge clock);
    chk("reset", 4'hF, 8'hFF);
    reset = 1'b1;

    scan("s1", 16'h1234, 1'b0);
    scan("s2", 16'h1234, 1'b0);
    scan("s3", 16'hABCD, 1'b1);
    scan("s4", 16'hABCD, 1'b1);

    part("s5", 16'h1234, 1'b0, 0, 8);
    ReadDataA = 16'h5678;
    part("s5tear", 16'h1234, 1'b0, 9, 15);
    part("s6", 16'h5678, 1'b0, 0, 8);
    selMode = 2'b10;
    part("s6b", 16'h5678, 1'b0, 9, 15);

    scan("s7", 16'hABCD, 1'b1);
    scan("s8", 16'hABCD, 1'b1);
    part("s9", 16'hABCD, 1'b1, 0, 8);
    selMode = 2'b01;
    part("s9b", 16'hABCD, 1'b1, 9, 15);
    scan("s10", 16'h5678, 1'b0);

    part("s11", 16'h5678, 1'b0, 0, 8);
    selMode = 2'b00;
    part("s11b", 16'h5678, 1'b0, 9, 15);
    part("s12", 16'h5678, 1'b0, 0, 8);
    selMode = 2'b11;
    ReadDataA = 16'hFFFF;
    part("s12b", 16'h5678, 1'b0, 9, 15);
    scan("s13frz", 16'h5678, 1'b0);
    part("s14frz", 16'h5678, 1'b0, 0, 8);
    selMode = 2'b00;
    part("s14b", 16'h5678, 1'b0, 9, 15);

    part("s15", 16'hABCD, 1'b1, 0, 9);
    reset = 1'b0;
    #1;
    chk("asyncrst", 4'hF, 8'hFF);
    @(negedge clock);
    chk("rsthold", 4'hF, 8'hFF);
    reset = 1'b1;
    scan("s16", 16'hFFFF, 1'b0);
    scan("s17", 16'hFFFF, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
